fifo_rr_sched: RTL and testbench

Round-robin read scheduler that shares one output stream between `CH_NUM` FIFO read ports (e.g. the read sides of several `fifo_dc` instances clocked by the consumer clock). It grants one channel at a time for a burst sized from that channel's `rd_avail`. It issues the reads, absorbs the 1-cycle registered RAM read latency, and presents tagged words on a valid/ready output with full back-pressure.

---
 rtl/fifo_rr_sched.sv | 201 ++++++++++++++++++++
 tb/tb_fifo_rr_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin burst read scheduler over CH_NUM FIFO read ports.
// One channel is granted at a time. Its burst length is latched from rd_avail
// and capped at BURST_LEN. Reads go through a one-cycle in-flight stage into a
// 2-entry output FIFO. A credit check keeps that FIFO from ever overflowing.
//
// Handshake: a word moves on out_* in any cycle where out_valid_o & out_ready_i.
// While out_valid_o is high and out_ready_i is low, out_data_o/out_ch_o/out_last_o
// hold their values. out_valid_o never drops without a transfer, except on reset.
module fifo_rr_sched #(
  parameter int CH_NUM    = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int BURST_LEN = 8,
  localparam int AW = $clog2(DEPTH) + 1,
  localparam int CW = $clog2(CH_NUM),
  localparam int LW = $clog2(BURST_LEN) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic [CH_NUM-1:0]       ch_rd_en_o,
  input  logic [CH_NUM*WIDTH-1:0] ch_rd_data_i,
  input  logic [CH_NUM-1:0]       ch_rd_empty_i,
  input  logic [CH_NUM*AW-1:0]    ch_rd_avail_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [CW-1:0]           out_ch_o,
  output logic                    out_last_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    busy_o,
  output logic                    dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   gnt_q, gnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   issued_q, issued_d;

  logic [CH_NUM-1:0] elig;
  logic              found;
  logic [CW-1:0]     cand;
  logic [AW-1:0]     cand_avail;
  logic [LW-1:0]     cand_len;

  logic              issue;
  logic              issue_last;
  logic              can_issue;
  logic [2:0]        credit_sum;

  logic              rd_vld_q;
  logic [CW-1:0]     rd_ch_q;
  logic              rd_last_q;
  logic [WIDTH-1:0]  rd_word;

  logic [WIDTH-1:0]  buf_data_q [2];
  logic [CW-1:0]     buf_ch_q   [2];
  logic              buf_last_q [2];
  logic              wr_idx_q;
  logic              rd_idx_q;
  logic [1:0]        occ_q;
  logic              push;
  logic              pop;

  // Channel index ptr+off, wrapped into 0..CH_NUM-1 (off is at most CH_NUM).
  function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= CH_NUM) s = s - CH_NUM;
    return CW'(s);
  endfunction

  // A channel is eligible when it reports words available and is not empty.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      elig[k] = (ch_rd_avail_i[k*AW +: AW] != '0) & ~ch_rd_empty_i[k];
    end
  end

  // Round-robin search starting one past the last grant; first hit wins.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= CH_NUM; i++) begin
      if (!found && elig[wrap_idx(ptr_q, i)]) begin
        found = 1'b1;
        cand  = wrap_idx(ptr_q, i);
      end
    end
  end

  // Burst length is min(avail, BURST_LEN). The compare is at full avail width.
  always_comb begin
    cand_avail = ch_rd_avail_i[int'(cand)*AW +: AW];
    if (cand_avail > AW'(BURST_LEN)) cand_len = LW'(BURST_LEN);
    else                             cand_len = cand_avail[LW-1:0];
  end

  // Output-FIFO credit: at most two words may be buffered or in flight.
  // pop is combinational on out_ready_i, so issue keeps pace at full rate.
  assign pop        = out_valid_o & out_ready_i;
  assign push       = rd_vld_q;
  assign credit_sum = {1'b0, occ_q} + {2'b00, rd_vld_q} - {2'b00, pop};
  assign can_issue  = credit_sum < 3'd2;

  // Scheduler next-state and read strobe. Strobes are held off while in
  // reset so that no channel word is popped and then thrown away.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    issued_d   = issued_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    ch_rd_en_o = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d    = cand;
          ptr_d    = cand;
          len_d    = cand_len;
          issued_d = '0;
          state_d  = S_BURST;
        end
      end
      S_BURST: begin
        issue      = can_issue & ~ch_rd_empty_i[gnt_q] & (issued_q < len_q) & ~rst_i;
        issue_last = (issued_q == (len_q - LW'(1)));
        ch_rd_en_o[gnt_q] = issue;
        if (issue) begin
          issued_d = issued_q + LW'(1);
          if (issue_last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler state registers; after reset channel 0 has first priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      ptr_q    <= CW'(CH_NUM - 1);
      gnt_q    <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      len_q    <= len_d;
      issued_q <= issued_d;
    end
  end

  // In-flight stage: covers the channel RAM's one-cycle registered read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_vld_q  <= 1'b0;
      rd_ch_q   <= '0;
      rd_last_q <= 1'b0;
    end else begin
      rd_vld_q  <= issue;
      rd_ch_q   <= gnt_q;
      rd_last_q <= issue & issue_last;
    end
  end

  assign rd_word = ch_rd_data_i[int'(rd_ch_q)*WIDTH +: WIDTH];

  // Two-entry output FIFO of {data, ch, last}, filled from the in-flight stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      wr_idx_q <= 1'b0;
      rd_idx_q <= 1'b0;
    end else begin
      if (push) begin
        buf_data_q[wr_idx_q] <= rd_word;
        buf_ch_q[wr_idx_q]   <= rd_ch_q;
        buf_last_q[wr_idx_q] <= rd_last_q;
        wr_idx_q             <= ~wr_idx_q;
      end
      if (pop) rd_idx_q <= ~rd_idx_q;
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // The head drives the output. Payload is forced to zero when nothing is held.
  always_comb begin
    out_valid_o = (occ_q != 2'd0);
    out_data_o  = out_valid_o ? buf_data_q[rd_idx_q] : '0;
    out_ch_o    = out_valid_o ? buf_ch_q[rd_idx_q]   : '0;
    out_last_o  = out_valid_o ? buf_last_q[rd_idx_q] : 1'b0;
    busy_o      = (state_q == S_BURST) | rd_vld_q | out_valid_o;
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Bench for fifo_rr_sched: channel FIFO read-side models, an output/strobe
// monitor, directed scenarios and a random soak.
module tb_fifo_rr_sched;
  localparam int CH_NUM    = 4;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 64;
  localparam int BURST_LEN = 8;
  localparam int AW        = $clog2(DEPTH) + 1;
  localparam int CW        = $clog2(CH_NUM);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH_NUM-1:0]       ch_rd_en;
  logic [CH_NUM*WIDTH-1:0] ch_rd_data;
  logic [CH_NUM-1:0]       ch_rd_empty;
  logic [CH_NUM*AW-1:0]    ch_rd_avail;
  logic [WIDTH-1:0]        out_data;
  logic [CW-1:0]           out_ch;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    busy;
  logic                    dbg_state;

  fifo_rr_sched #(.CH_NUM(CH_NUM), .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_rd_en_o(ch_rd_en), .ch_rd_data_i(ch_rd_data),
    .ch_rd_empty_i(ch_rd_empty), .ch_rd_avail_i(ch_rd_avail),
    .out_data_o(out_data), .out_ch_o(out_ch), .out_last_o(out_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- channel FIFO models ----------------
  int unsigned pushed [CH_NUM];
  int unsigned popped [CH_NUM];
  logic [WIDTH-1:0] exp_q [CH_NUM][$];

  function automatic logic [WIDTH-1:0] word_of(input int k, input int unsigned n);
    return {8'(k + 16), n[23:0]};
  endfunction

  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      ch_rd_avail[k*AW +: AW] = AW'(pushed[k] - popped[k]);
      ch_rd_empty[k]          = (pushed[k] == popped[k]);
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_rd_en[k]) begin
        ch_rd_data[k*WIDTH +: WIDTH] <= word_of(k, popped[k]);
        if (pushed[k] != popped[k]) popped[k] <= popped[k] + 1;
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct packed { logic [31:0] cyc; logic [CW-1:0] ch; logic last; logic [WIDTH-1:0] data; } obs_t;
  typedef struct packed { logic [31:0] cyc; logic [CW-1:0] ch; } rden_t;
  obs_t  obs_q[$];
  rden_t rden_q[$];
  obs_t  mon_o;
  rden_t mon_r;
  int unsigned cyc = 0;
  int empty_viol = 0, onehot_viol = 0, stab_viol = 0;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [CW-1:0] prev_ch;
  logic prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if ((ch_rd_en & ch_rd_empty) != '0) empty_viol++;
      if ($countones(ch_rd_en) > 1) onehot_viol++;
      for (int k = 0; k < CH_NUM; k++) begin
        if (ch_rd_en[k]) begin
          mon_r.cyc = cyc; mon_r.ch = CW'(k);
          rden_q.push_back(mon_r);
        end
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_ch !== prev_ch || out_last !== prev_last))
        stab_viol++;
      if (out_valid && out_ready) begin
        mon_o.cyc = cyc; mon_o.ch = out_ch; mon_o.last = out_last; mon_o.data = out_data;
        obs_q.push_back(mon_o);
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data; prev_ch = out_ch; prev_last = out_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_words(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q[k].push_back(word_of(k, pushed[k]));
      pushed[k] = pushed[k] + 1;
    end
  endtask

  // Reset pulse; words popped before reset are gone, so drop them from exp_q.
  task automatic do_reset(input int n);
    logic [WIDTH-1:0] h;
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    obs_q.delete();
    rden_q.delete();
    for (int k = 0; k < CH_NUM; k++) begin
      while (exp_q[k].size() > 0) begin
        h = exp_q[k][0];
        if ({8'h00, h[23:0]} < popped[k]) void'(exp_q[k].pop_front());
        else break;
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy && ch_rd_empty == '1) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    tick(); tick();
    checks += 7;
    if (ch_rd_en !== '0)  begin failures++; $display("FAIL reset_rd_en got=%b exp=0", ch_rd_en); end
    if (out_valid !== 0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (out_data !== '0)  begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    if (out_ch !== '0)    begin failures++; $display("FAIL reset_ch got=%0d exp=0", out_ch); end
    if (out_last !== 0)   begin failures++; $display("FAIL reset_last got=%b exp=0", out_last); end
    if (busy !== 0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (dbg_state !== 0)  begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    do_reset(1);
  endtask

  task automatic test_single_burst();
    int unsigned t0; bit ok; obs_t o; rden_t r; logic [WIDTH-1:0] e; int n;
    tick(); t0 = cyc;
    push_words(1, 3);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== (c >= 1 && c <= 5)) begin
        failures++; $display("FAIL single_busy cyc=+%0d got=%b exp=%b", c, busy, (c >= 1 && c <= 5));
      end
    end
    wait_idle(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=busy exp=idle"); end
    n = rden_q.size();
    checks++; if (n != 3) begin failures++; $display("FAIL single_rden_cnt got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      r = rden_q.pop_front();
      checks++;
      if (r.ch !== 1 || r.cyc !== 32'(t0 + 1 + i)) begin
        failures++; $display("FAIL single_rden i=%0d got=ch%0d@%0d exp=ch1@%0d", i, r.ch, r.cyc, t0 + 1 + i);
      end
    end
    n = obs_q.size();
    checks++; if (n != 3) begin failures++; $display("FAIL single_out_cnt got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front();
      e = (exp_q[1].size() > 0) ? exp_q[1].pop_front() : 'x;
      checks++;
      if (o.ch !== 1 || o.data !== e || o.last !== (i == 2) || o.cyc !== 32'(t0 + 3 + i)) begin
        failures++;
        $display("FAIL single_out i=%0d got=ch%0d %h last%b @%0d exp=ch1 %h last%b @%0d",
                 i, o.ch, o.data, o.last, o.cyc, e, (i == 2), t0 + 3 + i);
      end
    end
  endtask

  task automatic test_burst_cap();
    int unsigned t0; bit ok; obs_t o; rden_t r; logic [WIDTH-1:0] e; int n, b, j, blen;
    tick(); t0 = cyc;
    push_words(0, 20);
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL cap_timeout got=busy exp=idle"); end
    n = rden_q.size();
    checks++; if (n != 20) begin failures++; $display("FAIL cap_rden_cnt got=%0d exp=20", n); end
    for (int i = 0; i < n; i++) begin
      r = rden_q.pop_front(); b = i / 8; j = i % 8;
      checks++;
      if (r.ch !== 0 || r.cyc !== 32'(t0 + 1 + 9*b + j)) begin
        failures++; $display("FAIL cap_rden i=%0d got=ch%0d@%0d exp=ch0@%0d", i, r.ch, r.cyc, t0 + 1 + 9*b + j);
      end
    end
    n = obs_q.size();
    checks++; if (n != 20) begin failures++; $display("FAIL cap_out_cnt got=%0d exp=20", n); end
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front(); b = i / 8; j = i % 8; blen = (b < 2) ? 8 : 4;
      e = (exp_q[0].size() > 0) ? exp_q[0].pop_front() : 'x;
      checks++;
      if (o.ch !== 0 || o.data !== e || o.last !== (j == blen - 1) || o.cyc !== 32'(t0 + 3 + 9*b + j)) begin
        failures++;
        $display("FAIL cap_out i=%0d got=ch%0d %h last%b @%0d exp=ch0 %h last%b @%0d",
                 i, o.ch, o.data, o.last, o.cyc, e, (j == blen - 1), t0 + 3 + 9*b + j);
      end
    end
  endtask

  task automatic test_round_robin();
    int unsigned t0; bit ok; obs_t o; rden_t r; logic [WIDTH-1:0] e; int n, k, j;
    do_reset(2);
    for (int round = 0; round < 2; round++) begin
      tick(); t0 = cyc;
      for (int c = 0; c < CH_NUM; c++) push_words(c, 2);
      wait_idle(100, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rr_timeout round=%0d got=busy exp=idle", round); end
      n = rden_q.size();
      checks++; if (n != 8) begin failures++; $display("FAIL rr_rden_cnt got=%0d exp=8", n); end
      for (int i = 0; i < n; i++) begin
        r = rden_q.pop_front(); k = i / 2; j = i % 2;
        checks++;
        if (r.ch !== CW'(k) || r.cyc !== 32'(t0 + 1 + 3*k + j)) begin
          failures++; $display("FAIL rr_rden i=%0d got=ch%0d@%0d exp=ch%0d@%0d", i, r.ch, r.cyc, k, t0 + 1 + 3*k + j);
        end
      end
      n = obs_q.size();
      checks++; if (n != 8) begin failures++; $display("FAIL rr_out_cnt got=%0d exp=8", n); end
      for (int i = 0; i < n; i++) begin
        o = obs_q.pop_front(); k = i / 2; j = i % 2;
        e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 'x;
        checks++;
        if (o.ch !== CW'(k) || o.data !== e || o.last !== (j == 1)) begin
          failures++;
          $display("FAIL rr_out i=%0d got=ch%0d %h last%b exp=ch%0d %h last%b", i, o.ch, o.data, o.last, k, e, (j == 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned t0, tr; bit ok; obs_t o; rden_t r; logic [WIDTH-1:0] e, head; int n, stalled;
    tick(); t0 = cyc;
    push_words(2, 8);
    head = exp_q[2][1];
    repeat (4) tick();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1 || out_data !== head || out_ch !== 2 || out_last !== 0) begin
        failures++;
        $display("FAIL bp_hold cyc=+%0d got=v%b %h ch%0d last%b exp=v1 %h ch2 last0", c, out_valid, out_data, out_ch, out_last, head);
      end
    end
    tick(); tr = cyc;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ch_rd_en !== 4'b0100) begin failures++; $display("FAIL bp_resume got=%b exp=0100", ch_rd_en); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
    n = rden_q.size(); stalled = 0;
    checks++; if (n != 8) begin failures++; $display("FAIL bp_rden_cnt got=%0d exp=8", n); end
    for (int i = 0; i < n; i++) begin
      r = rden_q.pop_front();
      if (r.cyc >= t0 + 4 && r.cyc < tr) stalled++;
    end
    checks++; if (stalled > 2) begin failures++; $display("FAIL bp_stall_issue got=%0d exp<=2", stalled); end
    n = obs_q.size();
    checks++; if (n != 8) begin failures++; $display("FAIL bp_out_cnt got=%0d exp=8", n); end
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front();
      e = (exp_q[2].size() > 0) ? exp_q[2].pop_front() : 'x;
      checks++;
      if (o.ch !== 2 || o.data !== e || o.last !== (i == 7)) begin
        failures++; $display("FAIL bp_out i=%0d got=ch%0d %h last%b exp=ch2 %h last%b", i, o.ch, o.data, o.last, e, (i == 7));
      end
    end
    checks++; if (stab_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stab_viol); end
  endtask

  task automatic test_reset_mid_burst();
    int unsigned t0; bit ok; obs_t o; rden_t r; logic [WIDTH-1:0] e; int n, k, j;
    do_reset(2);
    tick(); t0 = cyc;
    push_words(0, 8);
    push_words(1, 5);
    repeat (4) tick();
    checks += 2;
    if (rden_q.size() != 3) begin failures++; $display("FAIL mid_pre_rden got=%0d exp=3", rden_q.size()); end
    if (obs_q.size() != 1) begin failures++; $display("FAIL mid_pre_out got=%0d exp=1", obs_q.size()); end
    else begin
      o = obs_q.pop_front(); e = exp_q[0].pop_front();
      checks++;
      if (o.data !== e || o.ch !== 0) begin failures++; $display("FAIL mid_pre_word got=ch%0d %h exp=ch0 %h", o.ch, o.data, e); end
    end
    do_reset(1);
    checks += 4;
    if (ch_rd_en !== '0 || busy !== 0) begin failures++; $display("FAIL mid_rst_ctl got=en%b busy%b exp=0 0", ch_rd_en, busy); end
    if (out_valid !== 0 || out_last !== 0) begin failures++; $display("FAIL mid_rst_valid got=v%b l%b exp=0 0", out_valid, out_last); end
    if (out_data !== '0 || out_ch !== '0) begin failures++; $display("FAIL mid_rst_data got=%h ch%0d exp=0 0", out_data, out_ch); end
    if (dbg_state !== 0) begin failures++; $display("FAIL mid_rst_state got=%b exp=0", dbg_state); end
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=busy exp=idle"); end
    n = rden_q.size();
    checks++; if (n != 10) begin failures++; $display("FAIL mid_rden_cnt got=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      r = rden_q.pop_front(); k = i / 5; j = i % 5;
      checks++;
      if (r.ch !== CW'(k) || r.cyc !== 32'(t0 + 6 + 6*k + j)) begin
        failures++; $display("FAIL mid_rden i=%0d got=ch%0d@%0d exp=ch%0d@%0d", i, r.ch, r.cyc, k, t0 + 6 + 6*k + j);
      end
    end
    n = obs_q.size();
    checks++; if (n != 10) begin failures++; $display("FAIL mid_out_cnt got=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front(); k = i / 5; j = i % 5;
      e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 'x;
      checks++;
      if (o.ch !== CW'(k) || o.data !== e || o.last !== (j == 4)) begin
        failures++; $display("FAIL mid_out i=%0d got=ch%0d %h last%b exp=ch%0d %h last%b", i, o.ch, o.data, o.last, k, e, (j == 4));
      end
    end
  endtask

  task automatic test_random_soak();
    bit ok; obs_t o; logic [WIDTH-1:0] e; int n, amt;
    for (int c = 0; c < 1500; c++) begin
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < CH_NUM; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          amt = $urandom_range(1, 4);
          if (pushed[k] - popped[k] + amt <= DEPTH) push_words(k, amt);
        end
      end
    end
    out_ready = 1'b1;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL soak_timeout got=busy exp=idle"); end
    rden_q.delete();
    n = obs_q.size();
    for (int i = 0; i < n; i++) begin
      o = obs_q.pop_front();
      checks++;
      if (exp_q[o.ch].size() == 0) begin
        failures++; $display("FAIL soak_extra i=%0d got=ch%0d %h exp=none", i, o.ch, o.data);
      end else begin
        e = exp_q[o.ch].pop_front();
        if (o.data !== e) begin failures++; $display("FAIL soak_data i=%0d ch%0d got=%h exp=%h", i, o.ch, o.data, e); end
      end
    end
    for (int k = 0; k < CH_NUM; k++) begin
      checks++;
      if (exp_q[k].size() != 0) begin failures++; $display("FAIL soak_lost ch%0d got=%0d left exp=0", k, exp_q[k].size()); end
    end
    checks += 3;
    if (empty_viol != 0)  begin failures++; $display("FAIL soak_rd_empty got=%0d exp=0", empty_viol); end
    if (onehot_viol != 0) begin failures++; $display("FAIL soak_onehot got=%0d exp=0", onehot_viol); end
    if (stab_viol != 0)   begin failures++; $display("FAIL soak_stable got=%0d exp=0", stab_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < CH_NUM; k++) pushed[k] = 0;
    test_reset();
    test_single_burst();
    test_burst_cap();
    test_round_robin();
    test_backpressure();
    test_reset_mid_burst();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
